// File: rtl/ped_signal_pkg.sv
// ped_signal_pkg
// Shared definitions for the pedestrian crossing controller:
//   - ped_state_t : controller state encoding (STOP, WALK, FLASH)
//   - DEF_*       : default timing constants used as parameter defaults
//   - is_onehot3  : helper used by the optional colour-input fault check
//                   (enabled with PED_FAULT_DETECT_EN)
package ped_signal_pkg;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    WALK  = 2'd1,
    FLASH = 2'd2
  } ped_state_t;

  localparam int DEF_WALK_CYCLES  = 16;
  localparam int DEF_FLASH_CYCLES = 12;
  localparam int DEF_FLASH_HALF   = 2;
  localparam int DEF_CNT_W        = 5;
  localparam int DEF_SYNC_STAGES  = 2;

  // True when exactly one of the three colour lamps is lit.
  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

endpackage

// File: rtl/ped_btn_sync.sv
// ped_btn_sync
// Brings the raw push-button into the clk domain through a flop chain and
// emits a single-cycle pulse on its rising edge. A held button yields one
// pulse only.
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high reset
//   btn    : raw asynchronous button, active-high
//   pulse  : one-cycle pulse, high in the cycle after the synchronised
//            level first reads 1 (derived purely from flops)
module ped_btn_sync
  import ped_signal_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic pulse
);

  // sync_reg[STAGES-1] is the synchronised level; sync_reg[STAGES] is its
  // one-cycle delayed copy used for edge detection.
  logic [STAGES:0] sync_reg;
  logic [STAGES:0] sync_next;

  assign sync_next = {sync_reg[STAGES-1:0], btn};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= sync_next;
    end
  end

  assign pulse = sync_reg[STAGES-1] & ~sync_reg[STAGES];

endmodule

// File: rtl/ped_signal_ctrl.sv
// ped_signal_ctrl
// Pedestrian crossing controller sitting downstream of the traffic light.
// A button press is latched as a pending request and served on the next
// rising edge of red: solid WALK for WALK_CYCLES, then flashing DONT_WALK
// with a countdown for FLASH_CYCLES, then solid DONT_WALK. If red drops
// while walking or flashing, the crossing is cut short and abort pulses.
// Optional feature macro: PED_FAULT_DETECT_EN adds a sticky 'fault'
// output that flags a non-one-hot {red,yellow,green} and holds the
// controller in STOP until reset.
// Ports:
//   clk, reset          : clock (rising edge), synchronous active-high reset
//   red, yellow, green  : lamp states from the traffic light (same domain)
//   ped_btn             : raw asynchronous push-button
//   req_pending         : request latched, not yet served
//   walk, dont_walk     : pedestrian lamps (dont_walk flashes in FLASH)
//   countdown           : remaining flash cycles, 0 outside FLASH
//   abort               : one-cycle pulse when WALK/FLASH is cut short
//   fault               : (PED_FAULT_DETECT_EN only) sticky colour fault
module ped_signal_ctrl
  import ped_signal_pkg::*;
#(
  parameter int WALK_CYCLES  = DEF_WALK_CYCLES,
  parameter int FLASH_CYCLES = DEF_FLASH_CYCLES,
  parameter int FLASH_HALF   = DEF_FLASH_HALF,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             red,
  input  logic             yellow,
  input  logic             green,
  input  logic             ped_btn,
  output logic             req_pending,
  output logic             walk,
  output logic             dont_walk,
  output logic [CNT_W-1:0] countdown,
  output logic             abort
`ifdef PED_FAULT_DETECT_EN
  ,
  output logic             fault
`endif
);

  localparam logic [CNT_W-1:0] WALK_LD  = CNT_W'(WALK_CYCLES);
  localparam logic [CNT_W-1:0] FLASH_LD = CNT_W'(FLASH_CYCLES);
  localparam logic [CNT_W-1:0] HALF_LD  = CNT_W'(FLASH_HALF);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  ped_state_t       state_reg, state_next;
  logic             red_q_reg;
  logic [CNT_W-1:0] walk_cnt_reg, walk_cnt_next;
  logic [CNT_W-1:0] half_cnt_reg, half_cnt_next;
  logic [CNT_W-1:0] countdown_reg, countdown_next;
  logic             walk_reg, walk_next;
  logic             dont_walk_reg, dont_walk_next;
  logic             req_reg, req_next;
  logic             abort_reg, abort_next;
  logic             flash_dw;
  logic             btn_edge;
  logic             red_rise;
  logic             hold_stop;

  ped_btn_sync u_btn_sync (
    .clk   (clk),
    .reset (reset),
    .btn   (ped_btn),
    .pulse (btn_edge)
  );

  assign red_rise = red & ~red_q_reg;

`ifdef PED_FAULT_DETECT_EN
  logic fault_reg;
  logic fault_now;

  // The offending sample itself already forces STOP, not just the cycles
  // after the sticky flag is set.
  assign fault_now = fault_reg | ~is_onehot3({red, yellow, green});
  assign hold_stop = fault_now;

  always_ff @(posedge clk) begin
    if (reset) begin
      fault_reg <= 1'b0;
    end else begin
      fault_reg <= fault_now;
    end
  end

  assign fault = fault_reg;
`else
  logic unused_colour;

  assign hold_stop     = 1'b0;
  assign unused_colour = yellow | green;
`endif

  always_comb begin
    state_next     = state_reg;
    walk_cnt_next  = walk_cnt_reg;
    half_cnt_next  = half_cnt_reg;
    countdown_next = countdown_reg;
    req_next       = req_reg;
    abort_next     = 1'b0;
    flash_dw       = 1'b1;
    walk_next      = 1'b0;
    dont_walk_next = 1'b1;

    case (state_reg)
      STOP: begin
        if (btn_edge) begin
          req_next = 1'b1;
        end
        // Serving the request also swallows a button edge in this cycle.
        if (red_rise && req_reg && !hold_stop) begin
          state_next    = WALK;
          req_next      = 1'b0;
          walk_cnt_next = WALK_LD;
        end
      end

      WALK: begin
        // Button edges are ignored: the crossing is already granted.
        if (!red) begin
          state_next = STOP;
          abort_next = 1'b1;
        end else if (walk_cnt_reg <= ONE) begin
          state_next     = FLASH;
          walk_cnt_next  = '0;
          countdown_next = FLASH_LD;
          half_cnt_next  = HALF_LD;
          flash_dw       = 1'b1;
        end else begin
          walk_cnt_next = walk_cnt_reg - ONE;
        end
      end

      FLASH: begin
        if (btn_edge) begin
          req_next = 1'b1;
        end
        if (!red) begin
          state_next = STOP;
          abort_next = 1'b1;
        end else if (countdown_reg <= ONE) begin
          state_next = STOP;
        end else begin
          countdown_next = countdown_reg - ONE;
          // Half-period counter reloads and flips the lamp on expiry.
          if (half_cnt_reg <= ONE) begin
            half_cnt_next = HALF_LD;
            flash_dw      = ~dont_walk_reg;
          end else begin
            half_cnt_next = half_cnt_reg - ONE;
            flash_dw      = dont_walk_reg;
          end
        end
      end

      default: begin
        state_next = STOP;
      end
    endcase

    if (hold_stop) begin
      state_next = STOP;
    end

    // Lamp and counter values follow the state being entered so that
    // every output is a plain register.
    case (state_next)
      WALK: begin
        walk_next      = 1'b1;
        dont_walk_next = 1'b0;
        countdown_next = '0;
      end
      FLASH: begin
        walk_next      = 1'b0;
        dont_walk_next = flash_dw;
      end
      default: begin
        walk_next      = 1'b0;
        dont_walk_next = 1'b1;
        countdown_next = '0;
        walk_cnt_next  = '0;
        half_cnt_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= STOP;
      red_q_reg     <= 1'b0;
      walk_cnt_reg  <= '0;
      half_cnt_reg  <= '0;
      countdown_reg <= '0;
      walk_reg      <= 1'b0;
      dont_walk_reg <= 1'b1;
      req_reg       <= 1'b0;
      abort_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      red_q_reg     <= red;
      walk_cnt_reg  <= walk_cnt_next;
      half_cnt_reg  <= half_cnt_next;
      countdown_reg <= countdown_next;
      walk_reg      <= walk_next;
      dont_walk_reg <= dont_walk_next;
      req_reg       <= req_next;
      abort_reg     <= abort_next;
    end
  end

  assign req_pending = req_reg;
  assign walk        = walk_reg;
  assign dont_walk   = dont_walk_reg;
  assign countdown   = countdown_reg;
  assign abort       = abort_reg;

endmodule
